// File: rtl/parity_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : parity_arbiter                                             |
// | Description : Round-robin arbiter that shares one registered parity     |
// |               stage among NUM_REQ requesters. A winner's word is         |
// |               captured, its parity computed in a single CALC cycle, and  |
// |               the word, parity bit and owner ID are presented on a       |
// |               valid/ready output port.                                   |
// | Ports       : clk, rst_n        - clock, asynchronous active-low reset   |
// |               req, req_data     - per-requester level request and word   |
// |               gnt               - one-hot grant, capture cycle only      |
// |               out_valid/ready   - result handshake                       |
// |               out_data/parity/id- result word, parity bit, owner index   |
// |               busy              - high whenever not IDLE                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module parity_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ODD     = 0,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_parity,
  output logic [ID_W-1:0]             out_id,
  output logic                        busy
);

  localparam logic            c_odd_bit   = (ODD != 0);
  localparam logic [ID_W:0]   c_num_req   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] c_last_id   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q,   ptr_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic                par_q,   par_d;
  logic [ID_W-1:0]     id_q,    id_d;

  // Per-requester words unpacked from the flat input bus.
  logic [DATA_W-1:0]   req_word [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // ------------------------------------------------------------------------
  // Round-robin selection. The request vector is duplicated and sliced at
  // ptr so that bit k of req_rot is requester (ptr+k) mod NUM_REQ; the
  // lowest set bit of req_rot is therefore the first requester in search
  // order starting from ptr.
  // ------------------------------------------------------------------------
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 win_found;
  logic [ID_W-1:0]      win_off;
  logic [ID_W:0]        win_sum;
  logic [ID_W-1:0]      win_id;
  logic [ID_W-1:0]      ptr_after_win;

  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr_q +: NUM_REQ];

  always_comb begin
    win_found = 1'b0;
    win_off   = '0;
    // Descending scan so the lowest offset overwrites last and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_found = 1'b1;
        win_off   = ID_W'(k);
      end
    end
  end

  always_comb begin
    win_sum = {1'b0, ptr_q} + {1'b0, win_off};
    if (win_sum >= c_num_req) begin
      win_sum = win_sum - c_num_req;
    end
    win_id = win_sum[ID_W-1:0];
  end

  // Explicit wrap keeps non-power-of-two NUM_REQ correct.
  assign ptr_after_win = (win_id == c_last_id) ? '0 : (win_id + 1'b1);

  // ------------------------------------------------------------------------
  // State register and datapath flops.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      par_q   <= par_d;
      id_q    <= id_d;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state and grant logic.
  // ------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    par_d   = par_q;
    id_d    = id_q;
    gnt     = '0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          // Grant is gated by rst_n so it reads 0 while reset is held,
          // even though the idle state itself would otherwise grant.
          gnt     = rst_n ? (NUM_REQ'(1) << win_id) : '0;
          data_d  = req_word[win_id];
          id_d    = win_id;
          ptr_d   = ptr_after_win;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        par_d   = (^data_q) ^ c_odd_bit;
        state_d = ST_OUT;
      end

      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Output port. Result fields are forced to 0 whenever nothing is valid so
  // stale captures never leak onto the bus.
  // ------------------------------------------------------------------------
  always_comb begin
    out_valid  = (state_q == ST_OUT);
    busy       = (state_q != ST_IDLE);
    out_data   = out_valid ? data_q : '0;
    out_parity = out_valid ? par_q  : 1'b0;
    out_id     = out_valid ? id_q   : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_parity_arbiter                                          |
// | Description : Scoreboard bench for parity_arbiter. Two instances (even   |
// |               and odd parity) share stimulus; a transaction-level model  |
// |               predicts grants and queues expected results, a monitor     |
// |               compares every cycle and pops on each handshake.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_parity_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NR-1:0]       req;
  logic [NR*DW-1:0]    req_data;
  logic                out_ready;

  logic [NR-1:0]       gnt_e,   gnt_o;
  logic                valid_e, valid_o;
  logic [DW-1:0]       data_e,  data_o;
  logic                par_e,   par_o;
  logic [IW-1:0]       id_e,    id_o;
  logic                busy_e,  busy_o;

  always #5 clk = ~clk;

  parity_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ODD(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt_e),
    .out_valid(valid_e), .out_ready(out_ready), .out_data(data_e),
    .out_parity(par_e), .out_id(id_e), .busy(busy_e)
  );

  parity_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt_o),
    .out_valid(valid_o), .out_ready(out_ready), .out_data(data_o),
    .out_parity(par_o), .out_id(id_o), .busy(busy_o)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int data;
    int par;   // even-parity bit; the odd instance expects its complement
    int id;
  } exp_t;

  exp_t exp_q[$];
  int   m_phase;    // 0 waiting for a request, 1 parity cycle, 2 presenting
  int   m_ptr;
  int   last_win;   // requester captured at the most recent edge, or -1
  int   checks = 0;
  int   errors = 0;

  function automatic int rr_pick(logic [NR-1:0] r, int p);
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic int even_par(int d);
    return $countones(d[DW-1:0]) % 2;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase  = 0;
    m_ptr    = 0;
    last_win = -1;
    exp_q.delete();
  endtask

  // Applied at each rising edge with the inputs that were stable before it.
  task automatic model_edge();
    int w;
    last_win = -1;
    if (!rst_n) begin
      m_reset();
      return;
    end
    case (m_phase)
      0: begin
        w = rr_pick(req, m_ptr);
        if (w >= 0) begin
          exp_t e;
          e.data = int'(req_data[w*DW +: DW]);
          e.par  = even_par(e.data);
          e.id   = w;
          exp_q.push_back(e);
          m_ptr    = (w + 1) % NR;
          last_win = w;
          m_phase  = 1;
        end
      end
      1: m_phase = 2;
      default: if (out_ready) m_phase = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int eg;
    int exp_gnt;
    if (!rst_n) begin
      chk("rst_gnt",    int'(gnt_e),   0);
      chk("rst_valid",  int'(valid_e), 0);
      chk("rst_data",   int'(data_e),  0);
      chk("rst_parity", int'(par_e),   0);
      chk("rst_id",     int'(id_e),    0);
      chk("rst_busy",   int'(busy_e),  0);
      chk("rst_gnt_odd", int'(gnt_o),  0);
    end else begin
      eg      = (m_phase == 0) ? rr_pick(req, m_ptr) : -1;
      exp_gnt = (eg >= 0) ? (1 << eg) : 0;
      chk("gnt",       int'(gnt_e),   exp_gnt);
      chk("gnt_odd",   int'(gnt_o),   exp_gnt);
      chk("busy",      int'(busy_e),  int'(m_phase != 0));
      chk("out_valid", int'(valid_e), int'(m_phase == 2));
      chk("out_valid_odd", int'(valid_o), int'(m_phase == 2));
      if (m_phase == 2) begin
        chk("sb_has_entry", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("out_data",       int'(data_e), exp_q[0].data);
          chk("out_parity",     int'(par_e),  exp_q[0].par);
          chk("out_id",         int'(id_e),   exp_q[0].id);
          chk("out_parity_odd", int'(par_o),  1 - exp_q[0].par);
          chk("out_id_odd",     int'(id_o),   exp_q[0].id);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_data",   int'(data_e), 0);
        chk("idle_parity", int'(par_e),  0);
        chk("idle_id",     int'(id_e),   0);
        chk("idle_parity_odd", int'(par_o), 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_word(int i, int v);
    req_data[i*DW +: DW] = DW'(v);
  endtask

  task automatic drop_granted();
    if (last_win >= 0) req[last_win] = 1'b0;
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    for (int c = 0; c < n; c++) begin
      req       = NR'($urandom);
      out_ready = 1'($urandom);
      req_data  = (NR*DW)'($urandom);
      tick();
    end
    rst_n     = 1'b1;
    req       = '0;
    out_ready = 1'b1;
  endtask

  // Requesters hold until granted; afterwards they may drop or queue anew.
  task automatic rand_inputs();
    for (int i = 0; i < NR; i++) begin
      if (req[i] && last_win != i) continue;
      if (req[i]) req[i] = ($urandom_range(0, 3) == 0);
      else        req[i] = ($urandom_range(0, 2) == 0);
      if (req[i]) set_word(i, int'($urandom_range(0, 255)));
    end
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    m_reset();
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    out_ready = 1'b0;

    // Reset with random inputs, then a single request from requester 0.
    do_reset(4);
    set_word(0, 8'h07);
    req = 4'b0001;
    tick();
    drop_granted();
    for (int c = 0; c < 5; c++) tick();

    // All four requesting from a fresh pointer: strict rotation and wrap.
    do_reset(2);
    set_word(0, 8'h00); set_word(1, 8'h01); set_word(2, 8'h03); set_word(3, 8'h0F);
    req = 4'b1111;
    for (int c = 0; c < 14; c++) begin
      tick();
      drop_granted();
    end

    // Fairness: requesters 0 and 2 held continuously.
    req = 4'b0101;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (last_win >= 0) set_word(last_win, int'($urandom_range(0, 255)));
    end
    req = '0;
    for (int c = 0; c < 4; c++) tick();

    // Backpressure: five extra stalled cycles in OUT with another request
    // waiting, then release.
    set_word(1, 8'hA5);
    req       = 4'b0010;
    out_ready = 1'b0;
    tick();
    drop_granted();
    tick();
    set_word(3, 8'h3C);
    req[3] = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      drop_granted();
    end

    // Reset while presenting a result: out_valid must fall without an edge.
    set_word(0, 8'h5A);
    req       = 4'b0001;
    out_ready = 1'b0;
    tick();
    drop_granted();
    tick();
    #2;
    chk("valid_before_rst", int'(valid_e), 1);
    rst_n = 1'b0;
    #1;
    chk("valid_async_drop",     int'(valid_e), 0);
    chk("valid_async_drop_odd", int'(valid_o), 0);
    chk("busy_async_drop",      int'(busy_e),  0);
    m_reset();
    tick();
    tick();
    rst_n = 1'b1;
    set_word(0, 8'h81);
    set_word(3, 8'hFE);
    req       = 4'b1001;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      drop_granted();
    end

    // Randomized traffic with occasional one-cycle resets.
    for (int c = 0; c < 2000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      rand_inputs();
    end
    rst_n = 1'b1;
    req   = '0;
    for (int c = 0; c < 6; c++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
